// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target with a NUM_REGS x DATA_W register file.
// Writes commit on nCS rise; reads shift reg[addr] out on CIPO.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         CIPO_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CW    = $clog2(FRAME + 2);

    localparam logic [CW-1:0] C_ADDR  = CW'(ADDR_W);
    localparam logic [CW-1:0] C_LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0] C_FRAME = CW'(FRAME);
    localparam logic [CW-1:0] C_SAT   = CW'(FRAME + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_END
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sy, copi_sy, ncs_sy;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    logic [CW-1:0]          cnt;
    logic [FRAME-1:0]       sh;
    logic [DATA_W-1:0]      tx;
    logic                   oe_q, cipo_q, eval_q;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   f_rw;
    logic [ADDR_W-1:0]      f_addr;
    logic [DATA_W-1:0]      f_data;
    logic                   out_en;
    logic [NUM_REGS*DATA_W-1:0] reg_q;

    // Synchronise the async SPI pins; keep one extra copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sy <= '0;
            copi_sy <= '0;
            ncs_sy  <= '1;
            sclk_d  <= 1'b0;
            ncs_d   <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], SCLK};
            copi_sy <= {copi_sy[SYNC_STAGES-2:0], COPI};
            ncs_sy  <= {ncs_sy[SYNC_STAGES-2:0], nCS};
            sclk_d  <= sclk_sy[SYNC_STAGES-1];
            ncs_d   <= ncs_sy[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sy[SYNC_STAGES-1];
    assign copi_s    = copi_sy[SYNC_STAGES-1];
    assign ncs_s     = ncs_sy[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d;

    assign rd_addr = {sh[ADDR_W-2:0], copi_s};
    assign f_rw    = sh[FRAME-1];
    assign f_addr  = sh[FRAME-2 -: ADDR_W];
    assign f_data  = sh[DATA_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: framing by chip select, phase by bit count
    always_comb begin
        state_nxt = state;
        if (ncs_fall) begin
            state_nxt = S_ADDR;
        end else if (ncs_rise) begin
            state_nxt = S_IDLE;
        end else if (sclk_rise && !ncs_s) begin
            case (state)
                S_ADDR:  if (cnt == C_ADDR) state_nxt = S_DATA;
                S_DATA:  if (cnt == C_LAST) state_nxt = S_END;
                default: state_nxt = state;
            endcase
        end
    end

    // Read mux; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = reg_q[i*DATA_W +: DATA_W];
        end
    end

    // Bit counter, receive shifter and read-back shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sh     <= '0;
            tx     <= '0;
            oe_q   <= 1'b0;
            cipo_q <= 1'b0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= 1'b0;
            if (ncs_fall) begin
                cnt    <= '0;
                sh     <= '0;
                tx     <= '0;
                oe_q   <= 1'b0;
                cipo_q <= 1'b0;
            end else if (ncs_rise) begin
                oe_q   <= 1'b0;
                cipo_q <= 1'b0;
                eval_q <= (state != S_IDLE);
            end else if (!ncs_s && state != S_IDLE) begin
                if (sclk_rise) begin
                    if (cnt != C_SAT) cnt <= cnt + 1'b1;
                    if (cnt < C_FRAME) sh <= {sh[FRAME-2:0], copi_s};
                    if (state == S_ADDR && cnt == C_ADDR && !sh[ADDR_W-1]) begin
                        tx   <= rd_data;
                        oe_q <= 1'b1;
                    end
                end
                if (sclk_fall && oe_q) begin
                    cipo_q <= tx[DATA_W-1];
                    tx     <= {tx[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // Commit or reject the finished frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q     <= '0;
            wr_addr   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (eval_q) begin
                if (cnt != C_FRAME) begin
                    frame_err <= 1'b1;
                end else if (f_rw) begin
                    if (int'(f_addr) < NUM_REGS) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (f_addr == ADDR_W'(i)) reg_q[i*DATA_W +: DATA_W] <= f_data;
                        end
                        wr_addr   <= f_addr;
                        wr_strobe <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_en   = !ncs_s && (state == S_DATA || state == S_END);
    assign CIPO     = cipo_q & out_en;
    assign CIPO_oe  = oe_q & out_en;
    assign reg_flat = reg_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench for spi_regfile_peripheral.
// Expected strobes/errors and read bits are queued as frames are sent.
module tb_spi_regfile_peripheral;

    logic        clk;
    logic        rst_n;
    logic        SCLK;
    logic        COPI;
    logic        nCS;
    logic        CIPO;
    logic        CIPO_oe;
    logic [39:0] reg_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        frame_err;

    typedef struct {
        logic [1:0] kind;
        logic [6:0] addr;
    } evt_t;

    evt_t        evq[$];
    logic        cq[$];
    logic [39:0] mdl;
    int          n_chk;
    int          n_fail;
    int          lat;

    spi_regfile_peripheral dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS),
        .CIPO      (CIPO),
        .CIPO_oe   (CIPO_oe),
        .reg_flat  (reg_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse monitor: every strobe/error must match the next queued event
    always @(negedge clk) begin
        if (rst_n && (wr_strobe || frame_err)) begin
            if (evq.size() == 0) begin
                chk("unexp_evt", {wr_strobe, frame_err}, 2'b00);
            end else begin
                evt_t e;
                e = evq.pop_front();
                chk("evt_kind", {wr_strobe, frame_err}, e.kind);
                if (wr_strobe) chk("wr_addr", wr_addr, e.addr);
            end
        end
    end

    // Drive n bits MSB first; nCS left low at the end
    task automatic spi_bits(input logic [31:0] bits, input int n, input bit rd);
        @(negedge clk) nCS = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            COPI = bits[n-1-i];
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            if (rd && i >= 8) begin
                if (cq.size() == 0) begin
                    chk("cipo_underflow", 1, 0);
                end else begin
                    chk("cipo_bit", CIPO, cq.pop_front());
                    chk("cipo_oe", CIPO_oe, 1'b1);
                end
            end
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_end(input int gap);
        @(negedge clk) nCS = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        evt_t e;
        e.addr = a;
        e.kind = (a < 5) ? 2'b10 : 2'b01;
        evq.push_back(e);
        spi_bits({16'h0, 1'b1, a, d}, 16, 1'b0);
        spi_end(12);
        if (a < 5) mdl[a*8 +: 8] = d;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
        for (int i = 7; i >= 0; i--) cq.push_back(exp[i]);
        spi_bits({16'h0, 1'b0, a, 8'h00}, 16, 1'b1);
        spi_end(12);
    endtask

    initial begin
        evt_t e;
        n_chk  = 0;
        n_fail = 0;
        mdl    = '0;
        rst_n  = 1'b0;
        SCLK   = 1'b0;
        COPI   = 1'b0;
        nCS    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_regs", reg_flat, 40'h0);
        chk("rst_outs", {CIPO, CIPO_oe, wr_strobe, wr_addr, frame_err}, 11'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: write reg2 = 0x5A, with commit latency
        e.kind = 2'b10;
        e.addr = 7'd2;
        evq.push_back(e);
        spi_bits(32'h825A, 16, 1'b0);
        @(negedge clk) nCS = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && reg_flat[23:16] == 8'h5A) lat = k;
        end
        chk("latency", lat, 4);
        mdl[23:16] = 8'h5A;
        repeat (6) @(negedge clk);
        chk("t1_regs", reg_flat, mdl);
        chk("t1_wr_addr", wr_addr, 7'd2);

        // 2: read back reg2
        do_read(7'd2, 8'h5A);
        chk("t2_regs", reg_flat, mdl);
        chk("idle_oe", CIPO_oe, 1'b0);

        // 3: short and long write frames
        e.kind = 2'b01;
        e.addr = 7'd0;
        evq.push_back(e);
        spi_bits(32'h8133 >> 1, 15, 1'b0);
        spi_end(12);
        evq.push_back(e);
        spi_bits(32'h8133 << 1, 17, 1'b0);
        spi_end(12);
        chk("t3_regs", reg_flat, mdl);

        // 4: out-of-range write and read
        do_write(7'd7, 8'hFF);
        chk("t4_regs", reg_flat, mdl);
        do_read(7'd7, 8'h00);

        // 5: reset in the middle of a write
        spi_bits(32'h8177 >> 7, 9, 1'b0);
        rst_n = 1'b0;
        nCS   = 1'b1;
        mdl   = '0;
        repeat (4) @(negedge clk);
        chk("t5_regs", reg_flat, 40'h0);
        chk("t5_outs", {CIPO, CIPO_oe, wr_strobe, wr_addr, frame_err}, 11'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_write(7'd1, 8'h77);
        chk("t5_after", reg_flat, mdl);

        // 6: back-to-back writes with a short gap
        e.kind = 2'b10;
        e.addr = 7'd0;
        evq.push_back(e);
        spi_bits(32'h8011, 16, 1'b0);
        spi_end(4);
        mdl[7:0] = 8'h11;
        e.addr = 7'd4;
        evq.push_back(e);
        spi_bits(32'h8444, 16, 1'b0);
        spi_end(12);
        mdl[39:32] = 8'h44;
        chk("t6_regs", reg_flat, mdl);
        chk("t6_wr_addr", wr_addr, 7'd4);

        do_read(7'd4, 8'h44);
        chk("evt_left", evq.size(), 0);
        chk("cipo_left", cq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
